// File: rtl/mem_pkg.sv
// Shared sizes and enums for the two-port arbitrated word memory.
// Pure declarations; no latency or backpressure.
package mem_pkg;
    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;
endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x DATA_W storage: write or read per enabled cycle, both synchronous.
// Latency 1 for reads; no backpressure, the caller owns the port every enabled cycle.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents and read register are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving requesters A and B one access per cycle to a shared memory.
// Latency: gnt the cycle after req is sampled, rdata/rvalid one cycle after gnt; req holds until gnt.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              CLK,
    input  logic              Clr,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy
);
    state_t            state_q, state_d;
    owner_t            owner_q, owner_d, last_owner_q, winner, rd_owner_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              any_req, rd_vld_q, mem_en;
    logic [DATA_W-1:0] mem_rdata, a_hold_q, b_hold_q;

    assign any_req = a_req | b_req;

    always_comb begin
        winner = OWN_A;
        if (a_req && b_req) begin
            winner = (last_owner_q == OWN_A) ? OWN_B : OWN_A;
        end else if (b_req) begin
            winner = OWN_B;
        end
    end

    // IDLE and ACCESS share one rule: any pending req starts an access next cycle,
    // including the current owner's req seen during its own gnt.
    always_comb begin
        state_d = IDLE;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (any_req) begin
            state_d = ACCESS;
            owner_d = winner;
            if (winner == OWN_A) begin
                we_d    = a_we;
                addr_d  = a_addr;
                wdata_d = a_wdata;
            end else begin
                we_d    = b_we;
                addr_d  = b_addr;
                wdata_d = b_wdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Clr) begin
            state_q      <= IDLE;
            owner_q      <= OWN_A;
            last_owner_q <= OWN_B;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_vld_q     <= 1'b0;
            rd_owner_q   <= OWN_A;
            a_hold_q     <= '0;
            b_hold_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (any_req) begin
                last_owner_q <= winner;
            end
            rd_vld_q   <= busy && !we_q;
            rd_owner_q <= owner_q;
            if (rd_vld_q) begin
                if (rd_owner_q == OWN_A) begin
                    a_hold_q <= mem_rdata;
                end else begin
                    b_hold_q <= mem_rdata;
                end
            end
        end
    end

    assign busy     = (state_q == ACCESS);
    assign a_gnt    = busy && (owner_q == OWN_A);
    assign b_gnt    = busy && (owner_q == OWN_B);
    assign a_rvalid = rd_vld_q && (rd_owner_q == OWN_A);
    assign b_rvalid = rd_vld_q && (rd_owner_q == OWN_B);
    assign a_rdata  = a_rvalid ? mem_rdata : a_hold_q;
    assign b_rdata  = b_rvalid ? mem_rdata : b_hold_q;

    // A reset edge must not let an in-flight write land.
    assign mem_en = busy && !Clr;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (1 << ADDR_W)
    ) u_mem (
        .clk   (CLK),
        .en    (mem_en),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven cycle checks plus handshake sequences; read data checked through a scoreboard.
module tb_mem_arbiter;
    logic       CLK = 1'b0;
    logic       Clr;
    logic       a_req, a_we, a_gnt, a_rvalid;
    logic [5:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req, b_we, b_gnt, b_rvalid;
    logic [5:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic       busy;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
        .CLK(CLK), .Clr(Clr),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .busy(busy)
    );

    typedef struct {
        logic       clr;
        logic       ar, awe;
        logic [5:0] aad;
        logic [7:0] awd;
        logic       br, bwe;
        logic [5:0] bad;
        logic [7:0] bwd;
        logic       eag, ebg;
    } vec_t;

    typedef struct {
        logic       own;
        logic [7:0] dat;
        logic       known;
        int         due;
    } sb_t;

    vec_t       tbl[$];
    sb_t        sb[$];
    logic [7:0] mdl   [64];
    logic       known [64];
    int         checks = 0;
    int         failures = 0;

    function automatic vec_t mk(input logic clr,
                                input logic ar, input logic awe, input logic [5:0] aad, input logic [7:0] awd,
                                input logic br, input logic bwe, input logic [5:0] bad, input logic [7:0] bwd,
                                input logic eag, input logic ebg);
        vec_t v;
        v.clr = clr; v.ar = ar; v.awe = awe; v.aad = aad; v.awd = awd;
        v.br = br; v.bwe = bwe; v.bad = bad; v.bwd = bwd; v.eag = eag; v.ebg = ebg;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, act, exp);
        end
    endtask

    // Handshake access: hold req until gnt (bounded), drop it in the gnt cycle, then check read data.
    task automatic access(input logic own, input logic we, input logic [5:0] addr, input logic [7:0] wd, input int id);
        logic got, rv;
        sb_t  e;
        if (own) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        else     begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge CLK); #1;
            got = own ? b_gnt : a_gnt;
        end
        a_req = 0; b_req = 0;
        chk("hs_gnt", id, {7'd0, got}, 8'd1);
        if (got) begin
            if (we) begin
                mdl[addr] = wd; known[addr] = 1;
            end else begin
                sb.push_back('{own, mdl[addr], known[addr], 0});
                rv = 0;
                for (int i = 0; i < 4 && !rv; i++) begin
                    @(posedge CLK); #1;
                    rv = own ? b_rvalid : a_rvalid;
                end
                chk("hs_rvalid", id, {7'd0, rv}, 8'd1);
                e = sb.pop_front();
                if (rv && e.known) chk("hs_rdata", id, own ? b_rdata : a_rdata, e.dat);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       v;
        sb_t        e;
        logic       pend_vld, exp_arv, exp_brv, exp_k;
        logic [5:0] pend_addr;
        logic [7:0] pend_wd, exp_dat, ha, hb;
        logic       hak, hbk;

        for (int i = 0; i < 64; i++) begin mdl[i] = 8'h00; known[i] = 1'b0; end
        Clr = 1; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;

        // clr | A req we addr wdata | B req we addr wdata | expected a_gnt b_gnt
        tbl.push_back(mk(1, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(1, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 1,0,6'h00,8'h00, 1,0,6'h00,8'h00, 1,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 1,0,6'h00,8'h00, 0,1));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 1,1,6'h3F,8'hA5, 0,0,6'h00,8'h00, 1,0));
        tbl.push_back(mk(0, 1,0,6'h3F,8'h00, 0,0,6'h00,8'h00, 1,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 1,0,6'h10,8'h00, 1,1,6'h10,8'h3C, 0,1));
        tbl.push_back(mk(0, 1,0,6'h10,8'h00, 0,0,6'h00,8'h00, 1,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 1,0,6'h3F,8'h00, 0,1));
        tbl.push_back(mk(0, 1,1,6'h11,8'h11, 1,1,6'h20,8'h22, 1,0));
        tbl.push_back(mk(0, 1,0,6'h11,8'h00, 1,1,6'h20,8'h22, 0,1));
        tbl.push_back(mk(0, 1,0,6'h11,8'h00, 1,0,6'h11,8'h00, 1,0));
        tbl.push_back(mk(0, 1,1,6'h00,8'h77, 1,0,6'h11,8'h00, 0,1));
        tbl.push_back(mk(0, 1,1,6'h00,8'h77, 1,0,6'h20,8'h00, 1,0));
        tbl.push_back(mk(0, 1,0,6'h00,8'h00, 1,0,6'h20,8'h00, 0,1));
        tbl.push_back(mk(0, 1,0,6'h00,8'h00, 0,0,6'h00,8'h00, 1,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 1,1,6'h05,8'h44, 0,1));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 1,1,6'h05,8'hFF, 0,0,6'h00,8'h00, 1,0));
        tbl.push_back(mk(1, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 1,0,6'h05,8'h00, 0,0,6'h00,8'h00, 1,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 1,0,6'h3F,8'h00, 1,0,6'h05,8'h00, 0,1));
        tbl.push_back(mk(0, 1,0,6'h3F,8'h00, 0,0,6'h00,8'h00, 1,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 1,0,6'h10,8'h00, 0,1));
        tbl.push_back(mk(1, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));
        tbl.push_back(mk(0, 0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0));

        pend_vld = 0; pend_addr = 0; pend_wd = 0;
        ha = 0; hb = 0; hak = 0; hbk = 0;
        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            Clr = v.clr;
            a_req = v.ar; a_we = v.awe; a_addr = v.aad; a_wdata = v.awd;
            b_req = v.br; b_we = v.bwe; b_addr = v.bad; b_wdata = v.bwd;
            @(posedge CLK); #1;

            // The write granted last row lands at this edge unless reset hits it.
            if (pend_vld && !v.clr) begin
                mdl[pend_addr] = pend_wd; known[pend_addr] = 1;
            end
            pend_vld = 0;

            exp_arv = 0; exp_brv = 0; exp_dat = 0; exp_k = 0;
            if (sb.size() > 0 && sb[0].due == r) begin
                e = sb.pop_front();
                if (!v.clr) begin
                    if (e.own) exp_brv = 1; else exp_arv = 1;
                    exp_dat = e.dat; exp_k = e.known;
                end
            end

            chk("a_gnt", r, {7'd0, a_gnt}, {7'd0, v.eag});
            chk("b_gnt", r, {7'd0, b_gnt}, {7'd0, v.ebg});
            chk("busy", r, {7'd0, busy}, {7'd0, v.eag | v.ebg});
            chk("a_rvalid", r, {7'd0, a_rvalid}, {7'd0, exp_arv});
            chk("b_rvalid", r, {7'd0, b_rvalid}, {7'd0, exp_brv});

            if (v.clr) begin ha = 0; hak = 1; hb = 0; hbk = 1; end
            if (exp_arv) begin
                if (exp_k) chk("a_rdata", r, a_rdata, exp_dat);
                ha = exp_dat; hak = exp_k;
            end else if (hak) begin
                chk("a_rdata_hold", r, a_rdata, ha);
            end
            if (exp_brv) begin
                if (exp_k) chk("b_rdata", r, b_rdata, exp_dat);
                hb = exp_dat; hbk = exp_k;
            end else if (hbk) begin
                chk("b_rdata_hold", r, b_rdata, hb);
            end

            if (v.eag) begin
                if (v.awe) begin pend_vld = 1; pend_addr = v.aad; pend_wd = v.awd; end
                else sb.push_back('{1'b0, mdl[v.aad], known[v.aad], r + 1});
            end
            if (v.ebg) begin
                if (v.bwe) begin pend_vld = 1; pend_addr = v.bad; pend_wd = v.bwd; end
                else sb.push_back('{1'b1, mdl[v.bad], known[v.bad], r + 1});
            end
        end

        Clr = 0; a_req = 0; b_req = 0;
        sb.delete();
        access(1'b0, 1'b1, 6'h2A, 8'h5A, 100);
        access(1'b0, 1'b0, 6'h2A, 8'h00, 101);
        access(1'b1, 1'b0, 6'h2A, 8'h00, 102);
        access(1'b1, 1'b1, 6'h01, 8'hC3, 103);
        access(1'b0, 1'b0, 6'h01, 8'h00, 104);
        access(1'b1, 1'b0, 6'h00, 8'h00, 105);
        repeat (2) @(posedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, address width (64 words).
REQ-002 Parameter DATA_W, default 8, word width.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Clr  input  1  reset, synchronous, active-high.
REQ-005 a_req  input  1  requester A access request, level, held until a_gnt.
REQ-006 a_we  input  1  A access type: 1 = write, 0 = read, stable while a_req.
REQ-007 a_addr  input  ADDR_W  A word address, stable while a_req.
REQ-008 a_wdata  input  DATA_W  A write data, stable while a_req.
REQ-009 a_gnt  output  1  one-cycle pulse: A's access is performed this cycle.
REQ-010 a_rvalid  output  1  one-cycle pulse: a_rdata holds A's read result.
REQ-011 a_rdata  output  DATA_W  A read data, valid only with a_rvalid.
REQ-012 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same directions, widths and meanings as A, for requester B.
REQ-013 busy  output  1  high in every ACCESS cycle.

Function
REQ-014 The FSM SHALL have two states: IDLE and ACCESS.
REQ-015 In IDLE with any request pending, the FSM SHALL move to ACCESS at the next edge, latching the owner, we, addr and wdata.
REQ-016 In ACCESS, the owner's gnt and busy SHALL be high, and the memory operation SHALL complete at the edge ending the cycle.
REQ-017 From ACCESS, the FSM SHALL re-enter ACCESS when the other requester's req is high, re-enter ACCESS when only the same requester's req is high, and otherwise return to IDLE.
REQ-018 The same requester's req seen during its own gnt cycle SHALL be treated as a new request.
REQ-019 Arbitration SHALL be round-robin: when both requests are high, the winner is the requester that is not last_owner.
REQ-020 When only one request is high, that requester SHALL win regardless of last_owner.
REQ-021 last_owner SHALL update to the winner each time ACCESS is entered.
REQ-022 Sustained throughput SHALL be one access per cycle; with both requesting continuously, grants SHALL alternate A, B, A, B.
REQ-023 A write SHALL store wdata at addr at the end of the ACCESS cycle.
REQ-024 A read SHALL drive the owner's rdata and rvalid in the cycle after ACCESS (latency 1 from gnt).
REQ-025 A read of an address written in the immediately preceding ACCESS cycle SHALL return the new data.
REQ-026 rdata SHALL hold its last value when rvalid is low.
REQ-027 The other requester's rvalid SHALL stay 0.
REQ-028 Addresses SHALL use all ADDR_W bits with no wrap or aliasing; all 2^ADDR_W words are addressable.
REQ-029 At most one gnt and at most one rvalid SHALL be high in any cycle.

Reset
REQ-030 While Clr is high at an edge: state to IDLE; last_owner to B, so A wins the first tie.
REQ-031 While Clr is high at an edge: all gnt, rvalid and busy to 0; a_rdata and b_rdata to 0.
REQ-032 A Clr edge during ACCESS SHALL abort any pending rvalid.
REQ-033 A write in an ACCESS cycle coinciding with a Clr edge SHALL NOT be performed.
REQ-034 Memory contents SHALL NOT be cleared by Clr.

Structure
REQ-035 Package mem_pkg SHALL hold ADDR_W, DATA_W and DEPTH defaults, the state enum (IDLE, ACCESS) and the owner enum (OWN_A, OWN_B).
REQ-036 Storage SHALL be one sub-module, mem_array: DEPTH x DATA_W, synchronous write, synchronous read, single port.
REQ-037 Arbitration, FSM and response routing SHALL live in mem_arbiter.

Verification
REQ-038 Scenario, reset release: after reset, a_req=1 with b_req=1, both reads of address 0 -> a_gnt first, b_gnt next cycle, rvalid pulses one cycle after each gnt.
REQ-039 Scenario, write then read: A writes 8'hA5 to address 6'h3F, then reads 6'h3F back-to-back -> a_rdata=8'hA5 one cycle after the read grant.
REQ-040 Scenario, contention: both requesters hold req for 6 cycles -> grants alternate A,B,A,B,A,B with no idle cycle between them.
REQ-041 Scenario, cross-port data: B writes 8'h3C to address 6'h10 while A reads 6'h10 in the next grant -> a_rdata=8'h3C.
REQ-042 Scenario, mid-operation reset: Clr asserted in the ACCESS cycle of an A write of 8'hFF to address 5 -> no rvalid follows; a later read of address 5 returns the prior value; B wins the next tie.
